// File: rtl/uart_tx_frame_ctrl_if.sv
// Host-side load/start handshake and serial status for uart_tx_frame_ctrl.
// The master modport belongs to the host and the slave modport to the transmitter.
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              load;
    logic [DATA_W-1:0] data_in;
    logic              tx_start;
    logic              tx;
    logic              busy;
    logic              loaded;
    logic              done;

    modport master (
        output load, data_in, tx_start,
        input  tx, busy, loaded, done
    );

    modport slave (
        input  load, data_in, tx_start,
        output tx, busy, loaded, done
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit controller: double-buffered holding register feeding a start/data/parity/stop serialiser.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_frame_ctrl #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_frame_ctrl_if.slave  bus_if
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_check
        $error("uart_tx_frame_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOADED = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd5
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   hold_q;
    logic [DATA_W-1:0]   shift_q;
    logic [BAUD_W-1:0]   baud_q;
    logic [BIT_W-1:0]    bit_q;
    logic                tx_q;
    logic                busy_q;
    logic                loaded_q;
    logic                done_q;
`ifdef UART_TX_PARITY_EN
    logic                parity_q;
`endif

    logic                start_ok;
    logic                loaded_d;
    logic                bit_end;
    logic [DATA_W-1:0]   hold_d;
    logic [BAUD_W-1:0]   baud_d;

    // A start may use either the held word or the word arriving on the same edge.
    always_comb begin
        hold_d   = bus_if.load ? bus_if.data_in : hold_q;
        start_ok = ((state_q == S_IDLE) || (state_q == S_LOADED)) &&
                   bus_if.tx_start && (loaded_q || bus_if.load);
        loaded_d = start_ok ? 1'b0 : (loaded_q | bus_if.load);
        bit_end  = (baud_q == BAUD_LAST);
        baud_d   = bit_end ? '0 : baud_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            shift_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            hold_q   <= hold_d;
            loaded_q <= loaded_d;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_LOADED: begin
                    if (start_ok) begin
                        state_q  <= S_START;
                        shift_q  <= hold_d;
`ifdef UART_TX_PARITY_EN
                        parity_q <= (^hold_d) ^ (PARITY_ODD != 0);
`endif
                        baud_q   <= '0;
                        bit_q    <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= loaded_d ? S_LOADED : S_IDLE;
                    end
                end
                S_START: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                S_DATA: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        if (bit_q == DATA_LAST) begin
                            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            // tx takes the bit that becomes shift[0] after this shift.
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        if (bit_q == STOP_LAST) begin
                            state_q <= loaded_d ? S_LOADED : S_IDLE;
                            bit_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.tx     = tx_q;
    assign bus_if.busy   = busy_q;
    assign bus_if.loaded = loaded_q;
    assign bus_if.done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: two instances (1 stop/even, 2 stop/odd) checked every cycle
// against a frame-level model, plus hand-computed frame bit patterns and timings.
module tb_uart_tx_frame_ctrl;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       ld  [2];
    logic [7:0] din [2];
    logic       st  [2];
    logic tx_w [2], busy_w [2], loaded_w [2], done_w [2];

    uart_tx_frame_ctrl_if #(.DATA_W(8)) bus0 ();
    uart_tx_frame_ctrl_if #(.DATA_W(8)) bus1 ();

    assign bus0.load = ld[0];  assign bus0.data_in = din[0];  assign bus0.tx_start = st[0];
    assign bus1.load = ld[1];  assign bus1.data_in = din[1];  assign bus1.tx_start = st[1];
    assign tx_w[0] = bus0.tx;  assign busy_w[0] = bus0.busy;  assign loaded_w[0] = bus0.loaded;  assign done_w[0] = bus0.done;
    assign tx_w[1] = bus1.tx;  assign busy_w[1] = bus1.busy;  assign loaded_w[1] = bus1.loaded;  assign done_w[1] = bus1.done;

    uart_tx_frame_ctrl #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(rst), .bus_if(bus0));
    uart_tx_frame_ctrl #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
        .clk(clk), .reset(rst), .bus_if(bus1));

    // ---------------- frame-level model ----------------
    typedef struct packed {
        logic       busy;
        logic [7:0] t;      // position within the frame, 1..F
        logic [7:0] word;
        logic       loaded;
        logic [7:0] hold;
        logic       done;
    } mdl_t;

    mdl_t m [2];

    function automatic int stop_bits(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int frame_len(int k);
        return CPB * (1 + DW + P + stop_bits(k));
    endfunction

    function automatic logic odd_sense(int k);
        return (k == 1);
    endfunction

    function automatic mdl_t step(mdl_t s, int k, logic l, logic [7:0] d, logic go);
        mdl_t n;
        logic accept;
        n      = s;
        n.done = 1'b0;
        accept = !s.busy && go && (s.loaded || l);
        if (s.busy) begin
            if (int'(s.t) == frame_len(k)) begin
                n.busy = 1'b0;
                n.done = 1'b1;
            end else begin
                n.t = s.t + 8'd1;
            end
        end else if (accept) begin
            n.busy = 1'b1;
            n.t    = 8'd1;
            n.word = l ? d : s.hold;
        end
        if (l) n.hold = d;
        n.loaded = accept ? 1'b0 : (s.loaded | l);
        return n;
    endfunction

    function automatic logic exp_tx(mdl_t s, int k);
        int idx;
        if (!s.busy) return 1'b1;
        idx = (int'(s.t) - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= DW) return s.word[idx-1];
        if (P == 1 && idx == DW + 1) return (^s.word) ^ odd_sense(k);
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) m[k] <= '0;
            else     m[k] <= step(m[k], k, ld[k], din[k], st[k]);
        end
    end

    // ---------------- checking ----------------
    int npass = 0;
    int ntot  = 0;

    task automatic chk(string nm, int act, int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_tx%0d", k),     int'(tx_w[k]),     int'(exp_tx(m[k], k)));
            chk($sformatf("model_busy%0d", k),   int'(busy_w[k]),   int'(m[k].busy));
            chk($sformatf("model_loaded%0d", k), int'(loaded_w[k]), int'(m[k].loaded));
            chk($sformatf("model_done%0d", k),   int'(done_w[k]),   int'(m[k].done));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_only(int k, logic [7:0] w);
        @(negedge clk); ld[k] = 1'b1; din[k] = w;
        @(negedge clk); ld[k] = 1'b0;
    endtask

    // Returns at the negedge of the first frame cycle.
    task automatic start_only(int k);
        @(negedge clk); st[k] = 1'b1;
        @(negedge clk); st[k] = 1'b0;
    endtask

    task automatic load_start(int k, logic [7:0] w);
        @(negedge clk); ld[k] = 1'b1; din[k] = w; st[k] = 1'b1;
        @(negedge clk); ld[k] = 1'b0; st[k] = 1'b0;
    endtask

    // Samples each bit mid-way, counts busy cycles and locates done relative to the first frame cycle.
    task automatic obs(int k, output logic [15:0] bits, output int busy_n, output int done_j);
        int nb;
        nb     = 1 + DW + P + stop_bits(k);
        bits   = '0;
        busy_n = 0;
        done_j = -1;
        for (int j = 0; j < 200; j++) begin
            if ((j % CPB) == 1 && (j / CPB) < nb) bits[j / CPB] = tx_w[k];
            if (busy_w[k]) busy_n++;
            if (done_w[k]) begin
                done_j = j;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] bits, bits2;
        int bn, dj, bn2, dj2, dones;

        for (int k = 0; k < 2; k++) begin ld[k] = 1'b0; din[k] = 8'h00; st[k] = 1'b0; end
        rst = 1'b1;
        cyc(3);
        chk("reset_tx",     int'(tx_w[0]),     1);
        chk("reset_busy",   int'(busy_w[0]),   0);
        chk("reset_loaded", int'(loaded_w[0]), 0);
        chk("reset_done",   int'(done_w[0]),   0);
        rst = 1'b0;
        cyc(2);

        // tx_start with nothing held is ignored
        @(negedge clk); st[0] = 1'b1;
        cyc(6);
        chk("nodata_busy", int'(busy_w[0]), 0);
        st[0] = 1'b0;
        cyc(2);

        // basic frame: load 0xA5, then start
        load_only(0, 8'hA5);
        chk("load_flag", int'(loaded_w[0]), 1);
        start_only(0);
        chk("start_tx0",  int'(tx_w[0]),   0);
        chk("start_busy", int'(busy_w[0]), 1);
        obs(0, bits, bn, dj);
        chk("a5_bits", int'(bits), (P == 1) ? 'h54A : 'h34A);
        chk("a5_busy", bn, (P == 1) ? 44 : 40);
        chk("a5_done", dj, (P == 1) ? 44 : 40);
        cyc(3);

        // two stop bits on the second instance
        load_only(1, 8'h0F);
        start_only(1);
        obs(1, bits, bn, dj);
        chk("0f_bits", int'(bits), (P == 1) ? 'hE1E : 'h61E);
        chk("0f_done", dj, (P == 1) ? 48 : 44);
        cyc(2);

        // odd parity sense
        load_start(1, 8'h01);
        obs(1, bits, bn, dj);
        chk("01_bits", int'(bits), (P == 1) ? 'hC02 : 'h602);
        cyc(2);
        load_start(1, 8'h03);
        obs(1, bits, bn, dj);
        chk("03_bits", int'(bits), (P == 1) ? 'hE06 : 'h606);
        cyc(2);

        // double buffering: load 0x3C mid-frame with tx_start held
        load_start(0, 8'h55);
        fork
            obs(0, bits, bn, dj);
            begin
                cyc(12);
                ld[0] = 1'b1; din[0] = 8'h3C; st[0] = 1'b1;
                cyc(1);
                ld[0] = 1'b0;
                cyc(8);
                chk("dbuf_loaded", int'(loaded_w[0]), 1);
            end
        join
        chk("55_bits", int'(bits), (P == 1) ? 'h4AA : 'h2AA);
        chk("55_done", dj, (P == 1) ? 44 : 40);
        chk("done_tx_idle", int'(tx_w[0]), 1);
        @(negedge clk); st[0] = 1'b0;
        chk("b2b_tx0",    int'(tx_w[0]),     0);
        chk("b2b_loaded", int'(loaded_w[0]), 0);
        obs(0, bits2, bn2, dj2);
        chk("3c_bits", int'(bits2), (P == 1) ? 'h478 : 'h278);
        chk("3c_busy", bn2, (P == 1) ? 44 : 40);
        cyc(2);

        // simultaneous load+start in IDLE
        load_start(0, 8'h81);
        chk("simul_loaded", int'(loaded_w[0]), 0);
        obs(0, bits, bn, dj);
        chk("81_bits", int'(bits), (P == 1) ? 'h502 : 'h302);
        cyc(2);

        // reset in the middle of a frame that also has a word buffered
        load_start(0, 8'hC3);
        cyc(5);
        ld[0] = 1'b1; din[0] = 8'h99;
        cyc(1);
        ld[0] = 1'b0;
        cyc(13);
        chk("pre_reset_busy", int'(busy_w[0]), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_tx",     int'(tx_w[0]),     1);
        chk("rst_mid_busy",   int'(busy_w[0]),   0);
        chk("rst_mid_loaded", int'(loaded_w[0]), 0);
        cyc(2);
        rst = 1'b0;
        dones = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (done_w[0]) dones++;
        end
        chk("rst_no_done", dones, 0);
        load_start(0, 8'hA5);
        obs(0, bits, bn, dj);
        chk("post_rst_bits", int'(bits), (P == 1) ? 'h54A : 'h34A);
        chk("post_rst_done", dj, (P == 1) ? 44 : 40);
        cyc(3);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
